adc_scan_sched: RTL and testbench
=================================

ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 Parameter PER_W, 29, width of scan-period counter.
REQ-002 Parameter TO_W, 16, width of end-of-conversion timeout counter.
REQ-003 Parameter CMD_BASE, 8'b10010111, SPI command template; bits [6:5] are replaced per channel.
REQ-004 clk_i  in  1  single system clock; all logic on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 en_i  in  1  periodic scanning enable.
REQ-007 button_i  in  1  one-cycle single-scan request pulse.
REQ-008 period_i  in  PER_W  scan period in clocks minus 1.
REQ-009 timeout_i  in  TO_W  max clocks to wait for eoc_i.
REQ-010 mask_i  in  4  channel enable mask, bit n = channel n.
REQ-011 clr_i  in  1  clears err_o and ovr_o.
REQ-012 strc_o  out  1  one-cycle start pulse to SPI engine.
REQ-013 cmd_o  out  8  command byte to SPI engine.
REQ-014 eoc_i  in  1  one-cycle end-of-conversion pulse from SPI engine.
REQ-015 data_i  in  12  conversion result, valid when eoc_i=1.
REQ-016 dout0_o..dout3_o  out  12 each  last result per channel.
REQ-017 upd_o  out  4  one-cycle pulse, bit n when dout n updates.
REQ-018 err_o  out  4  sticky timeout flag per channel.
REQ-019 ovr_o  out  1  sticky trigger-overrun flag.
REQ-020 busy_o  out  1  high in every state except IDLE.
REQ-021 eos_o  out  1  one-cycle end-of-scan pulse.

Function
REQ-022 Period counter runs 0..period_i while en_i=1 and produces tick at count==period_i, then wraps to 0; held at 0 while en_i=0.
REQ-023 Trigger = button_i OR tick.
REQ-024 States: IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-025 IDLE: on trigger (or pending flag set) with mask_i!=0, latch mask_i, select lowest set channel, clear pending, go ISSUE next cycle.
REQ-026 IDLE: trigger with mask_i==0 is ignored; no strc_o, no eos_o.
REQ-027 ISSUE: strc_o=1 for exactly this cycle, clear timeout counter, go WAIT.
REQ-028 cmd_o = {CMD_BASE[7], ch[0], ch[1], CMD_BASE[4:0]}; ch0=8'b10010111, ch1=8'b11010111, ch2=8'b10110111, ch3=8'b11110111; held stable from ISSUE through WAIT.
REQ-029 WAIT: eoc_i=1 -> register data_i into dout of current channel and pulse upd_o bit on the following cycle, go NEXT.
REQ-030 WAIT: timeout counter increments per cycle; count==timeout_i with eoc_i=0 -> set err_o bit of current channel, dout unchanged, go NEXT.
REQ-031 Simultaneous eoc_i and timeout: eoc_i wins, no error.
REQ-032 NEXT: select next higher set bit of latched mask -> ISSUE; none remaining -> DONE.
REQ-033 DONE: eos_o=1 for one cycle, go IDLE.
REQ-034 mask_i changes during a scan have no effect until the next scan.
REQ-035 Trigger while busy_o=1: set pending flag; trigger while pending already set: drop it and set ovr_o.
REQ-036 Latency: trigger in IDLE at cycle T -> strc_o at T+1; last eoc_i at E -> upd_o at E+1, eos_o at E+2.
REQ-037 clr_i clears err_o and ovr_o; a set event in the same cycle wins.
REQ-038 eoc_i outside WAIT is ignored.

Reset
REQ-039 rst_i=0 asynchronously forces IDLE, counters 0, pending 0, strc_o=0, cmd_o=CMD_BASE, dout*=0, upd_o=0, err_o=0, ovr_o=0, busy_o=0, eos_o=0.
REQ-040 Reset mid-scan aborts the scan; no eos_o is produced; the first scan after release requires a new trigger.

Verification
REQ-041 mask=4'b0011, button pulse, eoc after 40 clk with data 12'h123 then 12'h456 -> cmd 10010111 then 11010111, dout0=123, dout1=456, upd 0001 then 0010, eos one pulse.
REQ-042 mask=4'b1010, en=1, period=99 -> strc every scan only for ch1 and ch3 (cmd 11010111, 11110111), first scan 100 clk after enable.
REQ-043 timeout=50, no eoc on ch2, mask=4'b0100 -> err_o=4'b0100 after 51 WAIT cycles, eos still pulses, dout2 unchanged; clr_i -> err_o=0.
REQ-044 Three button pulses during one scan -> exactly one extra scan follows, ovr_o=1.
REQ-045 eoc_i in same cycle as count==timeout_i -> result stored, err_o stays 0.
REQ-046 rst_i low during WAIT -> all outputs at reset values immediately, no eos_o, idle until next trigger.

Source files
------------

// File: rtl/adc_scan_sched.sv
// adc_scan_sched: periodic/on-demand 4-channel ADC scan sequencer driving an SPI conversion engine.
module adc_scan_sched #(
  parameter int PER_W = 29,
  parameter int TO_W = 16,
  parameter logic [7:0] CMD_BASE = 8'b10010111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             button_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic [3:0]       mask_i,
  input  logic             clr_i,
  output logic             strc_o,
  output logic [7:0]       cmd_o,
  input  logic             eoc_i,
  input  logic [11:0]      data_i,
  output logic [11:0]      dout0_o,
  output logic [11:0]      dout1_o,
  output logic [11:0]      dout2_o,
  output logic [11:0]      dout3_o,
  output logic [3:0]       upd_o,
  output logic [3:0]       err_o,
  output logic             ovr_o,
  output logic             busy_o,
  output logic             eos_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]       st_q, st_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       msk_q, msk_d;
  logic [1:0]       ch_q, ch_d;
  logic             pend_q, pend_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [11:0]      dout_q [4];
  logic [11:0]      dout_d [4];
  logic [3:0]       upd_q, upd_d;
  logic [3:0]       err_q, err_d, err_set;
  logic             ovr_q, ovr_d, ovr_set;
  logic             tick, trig, nxt_vld;
  logic [1:0]       first_ch, nxt_ch;
  // Channel index lands bit-reversed in cmd[6:5]
  function automatic logic [7:0] cmd_of(input logic [1:0] c);
    return {CMD_BASE[7], c[0], c[1], CMD_BASE[4:0]};
  endfunction
  always_comb begin
    tick = en_i && (per_q == period_i);
    per_d = (!en_i || tick) ? '0 : per_q + 1'b1;
    trig = button_i | tick;
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) if (mask_i[i]) first_ch = 2'(i);
    nxt_vld = 1'b0;
    nxt_ch = ch_q;
    for (int i = 3; i >= 0; i--)
      if (msk_q[i] && (3'(i) > {1'b0, ch_q})) begin
        nxt_vld = 1'b1;
        nxt_ch = 2'(i);
      end
  end
  always_comb begin
    st_d = st_q;
    msk_d = msk_q;
    ch_d = ch_q;
    to_d = to_q;
    cmd_d = cmd_q;
    pend_d = pend_q;
    upd_d = '0;
    dout_d = dout_q;
    err_set = '0;
    ovr_set = 1'b0;
    case (st_q)
      S_IDLE:
        if ((trig || pend_q) && (mask_i != 4'd0)) begin
          st_d = S_ISSUE;
          msk_d = mask_i;
          ch_d = first_ch;
          pend_d = 1'b0;
          cmd_d = cmd_of(first_ch);
        end
      S_ISSUE: begin
        to_d = '0;
        st_d = S_WAIT;
      end
      S_WAIT:
        if (eoc_i) begin
          dout_d[ch_q] = data_i;
          upd_d[ch_q] = 1'b1;
          st_d = S_NEXT;
        end else if (to_q == timeout_i) begin
          err_set[ch_q] = 1'b1;
          st_d = S_NEXT;
        end else begin
          to_d = to_q + 1'b1;
        end
      S_NEXT:
        if (nxt_vld) begin
          st_d = S_ISSUE;
          ch_d = nxt_ch;
          cmd_d = cmd_of(nxt_ch);
        end else begin
          st_d = S_DONE;
        end
      default: st_d = S_IDLE;
    endcase
    // One trigger can queue behind a running scan; a second one is an overrun
    if (trig && (st_q != S_IDLE)) begin
      if (pend_q) ovr_set = 1'b1;
      else pend_d = 1'b1;
    end
    err_d = (clr_i ? 4'd0 : err_q) | err_set;
    ovr_d = (clr_i ? 1'b0 : ovr_q) | ovr_set;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q <= S_IDLE;
      per_q <= '0;
      to_q <= '0;
      msk_q <= '0;
      ch_q <= '0;
      pend_q <= 1'b0;
      cmd_q <= CMD_BASE;
      dout_q <= '{default: '0};
      upd_q <= '0;
      err_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      per_q <= per_d;
      to_q <= to_d;
      msk_q <= msk_d;
      ch_q <= ch_d;
      pend_q <= pend_d;
      cmd_q <= cmd_d;
      dout_q <= dout_d;
      upd_q <= upd_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
    end
  end
  assign strc_o = st_q == S_ISSUE;
  assign eos_o = st_q == S_DONE;
  assign busy_o = st_q != S_IDLE;
  assign cmd_o = cmd_q;
  assign upd_o = upd_q;
  assign err_o = err_q;
  assign ovr_o = ovr_q;
  assign dout0_o = dout_q[0];
  assign dout1_o = dout_q[1];
  assign dout2_o = dout_q[2];
  assign dout3_o = dout_q[3];
endmodule

// File: tb/tb_adc_scan_sched.sv
// tb_adc_scan_sched: directed scenario bench for adc_scan_sched.
module tb_adc_scan_sched;
  logic        clk_i, rst_i, en_i, button_i, clr_i, eoc_i;
  logic [28:0] period_i;
  logic [15:0] timeout_i;
  logic [3:0]  mask_i;
  logic [11:0] data_i;
  logic        strc_o, ovr_o, busy_o, eos_o;
  logic [7:0]  cmd_o;
  logic [11:0] dout0_o, dout1_o, dout2_o, dout3_o;
  logic [3:0]  upd_o, err_o;
  int          chk_cnt, pass_cnt, cyc;

  adc_scan_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .button_i(button_i),
    .period_i(period_i), .timeout_i(timeout_i), .mask_i(mask_i), .clr_i(clr_i),
    .strc_o(strc_o), .cmd_o(cmd_o), .eoc_i(eoc_i), .data_i(data_i),
    .dout0_o(dout0_o), .dout1_o(dout1_o), .dout2_o(dout2_o), .dout3_o(dout3_o),
    .upd_o(upd_o), .err_o(err_o), .ovr_o(ovr_o), .busy_o(busy_o), .eos_o(eos_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_button();
    button_i = 1'b1;
    step();
    button_i = 1'b0;
  endtask

  task automatic do_eoc(input logic [11:0] d);
    step();
    eoc_i = 1'b1;
    data_i = d;
    step();
    eoc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    step();
    step();
    chk_cnt++;
    if ({strc_o, busy_o, eos_o, ovr_o} !== 4'b0000) $display("FAIL reset_flags: got %b required 0000", {strc_o, busy_o, eos_o, ovr_o});
    else pass_cnt++;
    chk_cnt++;
    if (cmd_o !== 8'b10010111) $display("FAIL reset_cmd: got %b required 10010111", cmd_o);
    else pass_cnt++;
    chk_cnt++;
    if ({upd_o, err_o} !== 8'h00) $display("FAIL reset_upd_err: got %b required 00000000", {upd_o, err_o});
    else pass_cnt++;
    chk_cnt++;
    if ({dout0_o, dout1_o, dout2_o, dout3_o} !== 48'h0) $display("FAIL reset_dout: got %h required 0", {dout0_o, dout1_o, dout2_o, dout3_o});
    else pass_cnt++;
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_two_ch();
    int bad, n;
    mask_i = 4'b0011;
    timeout_i = 16'd1000;
    pulse_button();
    chk_cnt++;
    if ({strc_o, cmd_o} !== {1'b1, 8'b10010111}) $display("FAIL two_ch_issue0: got strc=%b cmd=%b required strc=1 cmd=10010111", strc_o, cmd_o);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (strc_o || cmd_o != 8'b10010111 || !busy_o) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL two_ch_wait0: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    eoc_i = 1'b1;
    data_i = 12'h123;
    step();
    eoc_i = 1'b0;
    chk_cnt++;
    if ({upd_o, dout0_o} !== {4'b0001, 12'h123}) $display("FAIL two_ch_res0: got upd=%b dout0=%h required upd=0001 dout0=123", upd_o, dout0_o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({strc_o, cmd_o, upd_o} !== {1'b1, 8'b11010111, 4'b0000}) $display("FAIL two_ch_issue1: got strc=%b cmd=%b upd=%b required strc=1 cmd=11010111 upd=0000", strc_o, cmd_o, upd_o);
    else pass_cnt++;
    for (int i = 0; i < 39; i++) step();
    eoc_i = 1'b1;
    data_i = 12'h456;
    step();
    eoc_i = 1'b0;
    chk_cnt++;
    if ({upd_o, dout1_o, dout0_o} !== {4'b0010, 12'h456, 12'h123}) $display("FAIL two_ch_res1: got upd=%b dout1=%h dout0=%h required upd=0010 dout1=456 dout0=123", upd_o, dout1_o, dout0_o);
    else pass_cnt++;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (eos_o) n++;
    end
    chk_cnt++;
    if (n != 1 || busy_o !== 1'b0) $display("FAIL two_ch_eos: got %0d eos pulses busy=%b required 1 pulse busy=0", n, busy_o);
    else pass_cnt++;
  endtask

  task automatic test_periodic();
    int n, c0;
    bit found;
    mask_i = 4'b1010;
    en_i = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 150 && !found; i++) begin
      step();
      if (strc_o) begin
        found = 1'b1;
        n = i;
      end
    end
    c0 = cyc;
    chk_cnt++;
    if (n != 100 || cmd_o !== 8'b11010111) $display("FAIL periodic_first: got strc after %0d clk cmd=%b required 100 clk cmd=11010111", n, cmd_o);
    else pass_cnt++;
    mask_i = 4'b0001;
    do_eoc(12'hA01);
    chk_cnt++;
    if ({upd_o, dout1_o} !== {4'b0010, 12'hA01}) $display("FAIL periodic_ch1: got upd=%b dout1=%h required upd=0010 dout1=a01", upd_o, dout1_o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({strc_o, cmd_o} !== {1'b1, 8'b11110111}) $display("FAIL periodic_ch3_issue: got strc=%b cmd=%b required strc=1 cmd=11110111", strc_o, cmd_o);
    else pass_cnt++;
    do_eoc(12'hA03);
    chk_cnt++;
    if ({upd_o, dout3_o} !== {4'b1000, 12'hA03}) $display("FAIL periodic_ch3: got upd=%b dout3=%h required upd=1000 dout3=a03", upd_o, dout3_o);
    else pass_cnt++;
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      step();
      if (strc_o) found = 1'b1;
    end
    chk_cnt++;
    if (!found || (cyc - c0) != 100 || cmd_o !== 8'b10010111) $display("FAIL periodic_second: got found=%b gap=%0d cmd=%b required found=1 gap=100 cmd=10010111", found, cyc - c0, cmd_o);
    else pass_cnt++;
    en_i = 1'b0;
    do_eoc(12'h0B0);
    step();
    step();
    chk_cnt++;
    if ({busy_o, dout0_o} !== {1'b0, 12'h0B0}) $display("FAIL periodic_end: got busy=%b dout0=%h required busy=0 dout0=0b0", busy_o, dout0_o);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int bad;
    mask_i = 4'b0100;
    timeout_i = 16'd50;
    pulse_button();
    chk_cnt++;
    if ({strc_o, cmd_o} !== {1'b1, 8'b10110111}) $display("FAIL timeout_issue: got strc=%b cmd=%b required strc=1 cmd=10110111", strc_o, cmd_o);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 51; i++) begin
      step();
      if (err_o != 4'b0000 || !busy_o) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL timeout_early: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({err_o, upd_o} !== {4'b0100, 4'b0000}) $display("FAIL timeout_err: got err=%b upd=%b required err=0100 upd=0000", err_o, upd_o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (eos_o !== 1'b1) $display("FAIL timeout_eos: got %b required 1", eos_o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({busy_o, dout2_o, err_o} !== {1'b0, 12'h000, 4'b0100}) $display("FAIL timeout_hold: got busy=%b dout2=%h err=%b required busy=0 dout2=000 err=0100", busy_o, dout2_o, err_o);
    else pass_cnt++;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk_cnt++;
    if (err_o !== 4'b0000) $display("FAIL timeout_clr: got %b required 0000", err_o);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n;
    mask_i = 4'b0001;
    timeout_i = 16'd1000;
    chk_cnt++;
    if (ovr_o !== 1'b0) $display("FAIL ovr_initial: got %b required 0", ovr_o);
    else pass_cnt++;
    pulse_button();
    step();
    pulse_button();
    step();
    pulse_button();
    step();
    pulse_button();
    chk_cnt++;
    if (ovr_o !== 1'b1) $display("FAIL ovr_set: got %b required 1", ovr_o);
    else pass_cnt++;
    do_eoc(12'h111);
    step();
    step();
    step();
    chk_cnt++;
    if ({strc_o, cmd_o} !== {1'b1, 8'b10010111}) $display("FAIL ovr_extra_scan: got strc=%b cmd=%b required strc=1 cmd=10010111", strc_o, cmd_o);
    else pass_cnt++;
    do_eoc(12'h222);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (strc_o) n++;
    end
    chk_cnt++;
    if (n != 0 || ovr_o !== 1'b1 || dout0_o !== 12'h222) $display("FAIL ovr_single_extra: got %0d further strc ovr=%b dout0=%h required 0 ovr=1 dout0=222", n, ovr_o, dout0_o);
    else pass_cnt++;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk_cnt++;
    if (ovr_o !== 1'b0) $display("FAIL ovr_clr: got %b required 0", ovr_o);
    else pass_cnt++;
  endtask

  task automatic test_eoc_timeout();
    mask_i = 4'b0001;
    timeout_i = 16'd3;
    pulse_button();
    for (int i = 0; i < 4; i++) step();
    eoc_i = 1'b1;
    data_i = 12'h5A5;
    step();
    eoc_i = 1'b0;
    chk_cnt++;
    if ({upd_o, err_o, dout0_o} !== {4'b0001, 4'b0000, 12'h5A5}) $display("FAIL eoc_vs_timeout: got upd=%b err=%b dout0=%h required upd=0001 err=0000 dout0=5a5", upd_o, err_o, dout0_o);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_mask_zero();
    int n;
    mask_i = 4'b0000;
    button_i = 1'b1;
    eoc_i = 1'b1;
    data_i = 12'hFFF;
    step();
    button_i = 1'b0;
    eoc_i = 1'b0;
    n = (strc_o || eos_o || busy_o || upd_o != 4'd0) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (strc_o || eos_o || busy_o || upd_o != 4'd0) n++;
    end
    chk_cnt++;
    if (n != 0 || dout0_o !== 12'h5A5) $display("FAIL mask_zero: got %0d active cycles dout0=%h required 0 dout0=5a5", n, dout0_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    mask_i = 4'b0001;
    timeout_i = 16'd1000;
    pulse_button();
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk_cnt++;
    if ({strc_o, busy_o, eos_o, cmd_o, dout0_o, upd_o} !== {3'b000, 8'b10010111, 12'h000, 4'b0000}) $display("FAIL reset_mid_async: got busy=%b cmd=%b dout0=%h upd=%b required busy=0 cmd=10010111 dout0=000 upd=0000", busy_o, cmd_o, dout0_o, upd_o);
    else pass_cnt++;
    step();
    rst_i = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      eoc_i = i[0];
      data_i = 12'h777;
      step();
      if (strc_o || eos_o || busy_o || upd_o != 4'd0) n++;
    end
    eoc_i = 1'b0;
    chk_cnt++;
    if (n != 0 || dout0_o !== 12'h000) $display("FAIL reset_mid_idle: got %0d active cycles dout0=%h required 0 dout0=000", n, dout0_o);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    cyc = 0;
    rst_i = 1'b1;
    en_i = 1'b0;
    button_i = 1'b0;
    clr_i = 1'b0;
    eoc_i = 1'b0;
    data_i = 12'h000;
    period_i = 29'd99;
    timeout_i = 16'd1000;
    mask_i = 4'b0000;
    test_reset();
    test_two_ch();
    test_periodic();
    test_timeout();
    test_overrun();
    test_eoc_timeout();
    test_mask_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
